// File: rtl/reset_sequencer_if.sv
// Handshake bundle between a reset_sequencer (slave) and the requester/remote reset domain (master).
interface reset_sequencer_if;
  logic req;
  logic ack;
  logic out_rst_n;
  logic busy;
  logic done;
  logic timed_out;

  modport master (
    output req,
    output ack,
    input  out_rst_n,
    input  busy,
    input  done,
    input  timed_out
  );

  modport slave (
    input  req,
    input  ack,
    output out_rst_n,
    output busy,
    output done,
    output timed_out
  );
endinterface

// File: rtl/reset_sequencer.sv
// Source-side reset initiator: holds a remote reset low, waits for the synchronized ack to rise and fall, pulses done.
// Optional RESET_SEQ_TIMEOUT_EN bounds each ack-wait state to TIMEOUT cycles and reports it on timed_out.
module reset_sequencer #(
  parameter int unsigned HOLDCYCLES = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNTW       = 8
) (
  input logic              clk,
  input logic              rst_n,
  reset_sequencer_if.slave bus
);

  localparam int unsigned SYNC_STAGES = 2;
  // The counter never needs to pass the largest value it is compared against.
  localparam int unsigned CNT_SPAN = (HOLDCYCLES > TIMEOUT) ? HOLDCYCLES : TIMEOUT;
  localparam logic [CNTW-1:0] CNT_SAT   = CNTW'(CNT_SPAN - 1);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLDCYCLES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [CNTW-1:0] WAIT_LAST = CNTW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            out_rst_n_q, out_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_sync;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] ack_sync_d;

`ifdef RESET_SEQ_TIMEOUT_EN
  logic timed_out_q, timed_out_d;
`endif

  genvar gi;

  assign ack_sync_d[0] = bus.ack;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_ack_sync
      assign ack_sync_d[gi] = ack_sync_q[gi-1];
    end
  endgenerate
  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNTW'(1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    timed_out_d = timed_out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.req) begin
          state_d = ST_ASSERT;
`ifdef RESET_SEQ_TIMEOUT_EN
          timed_out_d = 1'b0;
`endif
        end
      end
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == WAIT_LAST) begin
          state_d     = ST_RELEASE;
          cnt_d       = '0;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ST_RELEASE: begin
        if (!ack_sync) begin
          state_d = ST_FINISH;
          cnt_d   = '0;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt_q == WAIT_LAST) begin
          state_d     = ST_FINISH;
          cnt_d       = '0;
          timed_out_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop, not a decoder.
  always_comb begin
    out_rst_n_d = 1'b1;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE:                busy_d      = 1'b0;
      ST_ASSERT, ST_WAIT_ACK: out_rst_n_d = 1'b0;
      ST_FINISH:              done_d      = 1'b1;
      default:                ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      ack_sync_q  <= '0;
      out_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_sync_q  <= ack_sync_d;
      out_rst_n_q <= out_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timed_out_q <= 1'b0;
    end else begin
      timed_out_q <= timed_out_d;
    end
  end
  assign bus.timed_out = timed_out_q;
`else
  assign bus.timed_out = 1'b0;
`endif

  assign bus.out_rst_n = out_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: vector table, randomized ack windows against a timeline model, corner sequences.
module tb_reset_sequencer;

  localparam int H = 4;
  localparam int T = 10;

  logic clk = 1'b0;
  logic rst_n;

  reset_sequencer_if sif ();

  reset_sequencer #(
    .HOLDCYCLES(H),
    .TIMEOUT   (T),
    .CNTW      (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic req;
    logic ack;
    logic out_rst_n;
    logic busy;
    logic done;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string what, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", what, act, exp);
    end
  endtask

  task automatic chk_int(input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  // Ack sampled at relative edge x lies inside the remote domain's reset window [a,b).
  function automatic logic in_win(input int x, input int a, input int b);
    return (x >= a) && (x < b);
  endfunction

  // Remote domain that answers with ack = ~out_rst_n two cycles late; runs until busy drops.
  task automatic run_remote(input int maxc, output int lows, output int dones, output bit ok);
    logic [1:0] hist;
    hist  = {sif.out_rst_n, sif.out_rst_n};
    lows  = 0;
    dones = 0;
    ok    = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      sif.ack = ~hist[1];
      tick();
      hist = {hist[0], sif.out_rst_n};
      if (!sif.out_rst_n) lows++;
      if (sif.done) dones++;
      if (!sif.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int  lows, dones, a, b, r, f, cnt;
    bit  ok;
    logic e_out, e_busy, e_done;

    // Stale ack already high when the request is accepted.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n   = 1'b0;
    sif.req = 1'b0;
    sif.ack = 1'b0;

    // Power-up
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst%0d.out_rst_n", i), sif.out_rst_n, 1'b0);
      chk($sformatf("rst%0d.busy", i), sif.busy, 1'b1);
      chk($sformatf("rst%0d.done", i), sif.done, 1'b0);
      chk($sformatf("rst%0d.timed_out", i), sif.timed_out, 1'b0);
    end
    rst_n = 1'b1;
    run_remote(60, lows, dones, ok);
    chk("powerup.finished", ok, 1'b1);
    chk("powerup.low_ge_hold", (lows >= H), 1'b1);
    chk_int("powerup.done_pulses", dones, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_powerup%0d.out_rst_n", i), sif.out_rst_n, 1'b1);
      chk($sformatf("post_powerup%0d.busy", i), sif.busy, 1'b0);
      chk($sformatf("post_powerup%0d.done", i), sif.done, 1'b0);
    end
    $display("powerup: low_after_release=%0d done_pulses=%0d", lows, dones);

    // Vector table
    sif.ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 10; i++) begin
      sif.req = vecs[i].req;
      sif.ack = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d.out_rst_n", i), sif.out_rst_n, vecs[i].out_rst_n);
      chk($sformatf("vec%0d.busy", i), sif.busy, vecs[i].busy);
      chk($sformatf("vec%0d.done", i), sif.done, vecs[i].done);
      $display("vec %0d: req=%b ack=%b -> out_rst_n=%b busy=%b done=%b",
               i, vecs[i].req, vecs[i].ack, sif.out_rst_n, sif.busy, sif.done);
    end
    sif.req = 1'b0;

    // Randomized ack windows; REQ noise while busy must not start a second sequence.
    for (int s = 0; s < 25; s++) begin
      a = int'($urandom_range(0, 6));
      b = ((a + 1 > H) ? a + 1 : H) + int'($urandom_range(0, 4));
      r = H + 1;
      while (!in_win(r - 2, a, b)) r++;
      f = r + 1;
      while (in_win(f - 2, a, b)) f++;
      for (int rel = 0; rel <= f + 2; rel++) begin
        sif.req = (rel == 0) ? 1'b1 : ((rel <= f) ? 1'($urandom_range(0, 1)) : 1'b0);
        sif.ack = in_win(rel, a, b);
        tick();
        e_out  = (rel >= r);
        e_busy = (rel <= f);
        e_done = (rel == f);
        chk($sformatf("rnd%0d.rel%0d.out_rst_n", s, rel), sif.out_rst_n, e_out);
        chk($sformatf("rnd%0d.rel%0d.busy", s, rel), sif.busy, e_busy);
        chk($sformatf("rnd%0d.rel%0d.done", s, rel), sif.done, e_done);
        chk($sformatf("rnd%0d.rel%0d.timed_out", s, rel), sif.timed_out, 1'b0);
      end
      $display("rnd %0d: ack_window=[%0d,%0d) release_edge=%0d finish_edge=%0d", s, a, b, r, f);
    end
    sif.req = 1'b0;
    sif.ack = 1'b0;

`ifdef RESET_SEQ_TIMEOUT_EN
    // Ack stuck low: WAIT_ACK gives up after TIMEOUT cycles.
    sif.req = 1'b1;
    tick();
    sif.req = 1'b0;
    lows = 0;
    cnt  = 0;
    while (sif.out_rst_n == 1'b0 && cnt < 40) begin
      lows++;
      tick();
      cnt++;
    end
    chk_int("timeout.low_cycles", lows, H + T);
    chk("timeout.timed_out_set", sif.timed_out, 1'b1);
    tick();
    chk("timeout.done", sif.done, 1'b1);
    tick();
    chk("timeout.idle", sif.busy, 1'b0);
    chk("timeout.sticky", sif.timed_out, 1'b1);
    sif.req = 1'b1;
    sif.ack = 1'b1;
    tick();
    sif.req = 1'b0;
    chk("timeout.cleared_by_req", sif.timed_out, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    sif.ack = 1'b0;
    cnt = 0;
    while (sif.busy && cnt < 30) begin
      tick();
      cnt++;
    end
    chk("timeout.second_seq_finished", sif.busy, 1'b0);
    chk("timeout.second_seq_clean", sif.timed_out, 1'b0);
    $display("timeout: low_cycles=%0d", lows);
`else
    // Ack stuck high: parks in RELEASE until ack drops.
    sif.ack = 1'b1;
    sif.req = 1'b1;
    tick();
    sif.req = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sif.done) dones++;
    end
    chk_int("stuck.no_done", dones, 0);
    chk("stuck.out_rst_n", sif.out_rst_n, 1'b1);
    chk("stuck.busy", sif.busy, 1'b1);
    chk("stuck.timed_out", sif.timed_out, 1'b0);
    sif.ack = 1'b0;
    tick();
    chk("stuck.drop1.done", sif.done, 1'b0);
    tick();
    chk("stuck.drop2.done", sif.done, 1'b0);
    tick();
    chk("stuck.drop3.done", sif.done, 1'b1);
    tick();
    chk("stuck.idle", sif.busy, 1'b0);
    $display("stuck: parked 20 cycles, finished 3 cycles after ack drop");
`endif

    // Asynchronous reset in WAIT_ACK, then in RELEASE.
    sif.ack = 1'b0;
    sif.req = 1'b1;
    tick();
    sif.req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_wait.out_rst_n", sif.out_rst_n, 1'b0);
    chk("async_wait.busy", sif.busy, 1'b1);
    chk("async_wait.done", sif.done, 1'b0);
    sif.ack = 1'b1;
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= H; i++) begin
      tick();
      chk($sformatf("async_hold%0d.out_rst_n", i), sif.out_rst_n, 1'b0);
    end
    tick();
    chk("async_release.out_rst_n", sif.out_rst_n, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rel.out_rst_n", sif.out_rst_n, 1'b0);
    chk("async_rel.busy", sif.busy, 1'b1);
    chk("async_rel.timed_out", sif.timed_out, 1'b0);
    #1;
    rst_n = 1'b1;
    run_remote(60, lows, dones, ok);
    chk("async_restart.finished", ok, 1'b1);
    chk_int("async_restart.done_pulses", dones, 1);
    chk("async_restart.low_ge_hold", (lows >= H), 1'b1);
    $display("async: restart low_cycles=%0d done_pulses=%0d", lows, dones);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
